// File: rtl/wide_op_seq.sv
// 16-bit add/shl/shr/xor sequenced over an external 8-bit ALU, one byte per cycle; optional WIDE_OP_ZERO_FLAG_EN.
// Latency: response valid 2 edges after request accept; issue interval 4 cycles minimum.
// Backpressure: result held in DONE until rsp_ready; req_ready only in IDLE.
module wide_op_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_ci,
  output logic [3:0]  alu_cmd,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_sci,
  input  logic [7:0]  alu_rslt,
  input  logic        alu_sco,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_co,
  output logic        rsp_zero
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_SHR = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [15:0] a_q, b_q, res_q, final_res;
  logic        ci_q, carry_q, co_q;
  logic        hi_first, is_xor;
  logic [3:0]  op_cmd;

  assign hi_first = (op_q == OP_SHR);
  assign is_xor   = (op_q == OP_XOR);

  always_comb begin
    op_cmd = 4'b0000;
    case (op_q)
      OP_ADD: op_cmd = 4'b0000;
      OP_SHL: op_cmd = 4'b0001;
      OP_SHR: op_cmd = 4'b0010;
      OP_XOR: op_cmd = 4'b0101;
      default: op_cmd = 4'b0000;
    endcase
  end

  // Second-cycle byte merged with the byte captured in FIRST.
  assign final_res = hi_first ? {res_q[15:8], alu_rslt} : {alu_rslt, res_q[7:0]};

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_cmd   = 4'b0011;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_sci   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = FIRST;
      end
      FIRST: begin
        alu_cmd   = op_cmd;
        alu_a     = hi_first ? a_q[15:8] : a_q[7:0];
        alu_b     = hi_first ? b_q[15:8] : b_q[7:0];
        alu_sci   = is_xor ? 1'b0 : ci_q;
        state_nxt = SECOND;
      end
      SECOND: begin
        alu_cmd   = op_cmd;
        alu_a     = hi_first ? a_q[7:0] : a_q[15:8];
        alu_b     = hi_first ? b_q[7:0] : b_q[15:8];
        alu_sci   = is_xor ? 1'b0 : carry_q;
        state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 2'b00;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      ci_q    <= 1'b0;
      carry_q <= 1'b0;
      res_q   <= 16'h0000;
      co_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_q <= req_op;
          a_q  <= req_a;
          b_q  <= req_b;
          ci_q <= req_ci;
        end
        FIRST: begin
          if (hi_first) res_q[15:8] <= alu_rslt;
          else          res_q[7:0]  <= alu_rslt;
          carry_q <= alu_sco;
        end
        SECOND: begin
          res_q <= final_res;
          co_q  <= is_xor ? 1'b0 : alu_sco;
        end
        default: ;
      endcase
    end
  end

  assign rsp_data = res_q;
  assign rsp_co   = co_q;

`ifdef WIDE_OP_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               zero_q <= 1'b0;
    else if (state == SECOND) zero_q <= (final_res == 16'h0000);
  end
  assign rsp_zero = zero_q;
`else
  assign rsp_zero = 1'b0;
`endif

endmodule

// File: tb/tb_wide_op_seq.sv
// Directed bench for wide_op_seq with a behavioural 8-bit ALU attached.
module tb_wide_op_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_ci;
  logic [1:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [3:0]  alu_cmd;
  logic [7:0]  alu_a, alu_b, alu_rslt;
  logic        alu_sci, alu_sco;
  logic        rsp_valid, rsp_ready, rsp_co, rsp_zero;
  logic [15:0] rsp_data;

  int n_cmp = 0;
  int n_fail = 0;

`ifdef WIDE_OP_ZERO_FLAG_EN
  localparam logic ZEN = 1'b1;
`else
  localparam logic ZEN = 1'b0;
`endif

  always #5 clk = ~clk;

  wide_op_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_sci(alu_sci),
    .alu_rslt(alu_rslt), .alu_sco(alu_sco),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_co(rsp_co), .rsp_zero(rsp_zero)
  );

  // 8-bit ALU model
  always_comb begin
    alu_rslt = 8'h00;
    alu_sco  = 1'b0;
    case (alu_cmd)
      4'b0000: {alu_sco, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_sci};
      4'b0001: begin alu_rslt = {alu_a[6:0], alu_sci}; alu_sco = alu_a[7]; end
      4'b0010: begin alu_rslt = {alu_sci, alu_a[7:1]}; alu_sco = alu_a[0]; end
      4'b0101: alu_rslt = alu_a ^ alu_b;
      default: ;
    endcase
  end

  // Presents a request and returns at the falling edge of the FIRST cycle.
  task automatic start_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic keep_valid);
    bit ok = 0;
    req_op = op; req_a = a; req_b = b; req_ci = ci; req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL start_timeout: req_ready got 0 want 1"); end
    @(negedge clk);
    if (!keep_valid) req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 0; rsp_ready = 0; req_op = 0; req_a = 0; req_b = 0; req_ci = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if ({rsp_data, rsp_co, rsp_zero} !== 18'h0) begin n_fail++; $display("FAIL rst_rsp: got %h/%b/%b want 0", rsp_data, rsp_co, rsp_zero); end
    n_cmp++; if ({alu_cmd, alu_a, alu_b, alu_sci} !== {4'b0011, 17'h0}) begin n_fail++; $display("FAIL rst_alu: got cmd %b a %h b %h sci %b want 0011/00/00/0", alu_cmd, alu_a, alu_b, alu_sci); end
  endtask

  task automatic test_add_carry;
    start_op(2'b00, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    n_cmp++; if ({alu_cmd, alu_a, alu_b, alu_sci} !== {4'b0000, 8'hFF, 8'h01, 1'b0}) begin n_fail++; $display("FAIL add_first_drive: got %b %h %h %b want 0000 ff 01 0", alu_cmd, alu_a, alu_b, alu_sci); end
    n_cmp++; if ({req_ready, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL add_first_hs: got %b%b want 00", req_ready, rsp_valid); end
    @(negedge clk);
    n_cmp++; if ({alu_cmd, alu_a, alu_sci} !== {4'b0000, 8'h00, 1'b1}) begin n_fail++; $display("FAIL add_second_drive: got %b %h %b want 0000 00 1", alu_cmd, alu_a, alu_sci); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_second_valid: got %b want 0", rsp_valid); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid_2edges: got %b want 1", rsp_valid); end
    n_cmp++; if ({rsp_data, rsp_co, rsp_zero} !== {16'h0100, 1'b0, 1'b0}) begin n_fail++; $display("FAIL add_result: got %h co %b z %b want 0100 0 0", rsp_data, rsp_co, rsp_zero); end
    n_cmp++; if (alu_cmd !== 4'b0011) begin n_fail++; $display("FAIL done_alu_idle: got %b want 0011", alu_cmd); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL add_back_idle: got %b%b want 10", req_ready, rsp_valid); end
  endtask

  task automatic test_add_wrap;
    start_op(2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_data, rsp_co} !== {1'b1, 16'h0000, 1'b1}) begin n_fail++; $display("FAIL wrap_result: got v %b %h co %b want 1 0000 1", rsp_valid, rsp_data, rsp_co); end
    n_cmp++; if (rsp_zero !== ZEN) begin n_fail++; $display("FAIL wrap_zero: got %b want %b", rsp_zero, ZEN); end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_shl;
    start_op(2'b01, 16'h8001, 16'h5A5A, 1'b1, 1'b0);
    n_cmp++; if ({alu_cmd, alu_a, alu_sci} !== {4'b0001, 8'h01, 1'b1}) begin n_fail++; $display("FAIL shl_first_drive: got %b %h %b want 0001 01 1", alu_cmd, alu_a, alu_sci); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({rsp_data, rsp_co, rsp_zero} !== {16'h0003, 1'b1, 1'b0}) begin n_fail++; $display("FAIL shl_result: got %h co %b z %b want 0003 1 0", rsp_data, rsp_co, rsp_zero); end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_shr;
    start_op(2'b10, 16'h0003, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if ({alu_cmd, alu_a, alu_sci} !== {4'b0010, 8'h00, 1'b1}) begin n_fail++; $display("FAIL shr_first_high: got %b %h %b want 0010 00 1", alu_cmd, alu_a, alu_sci); end
    @(negedge clk);
    n_cmp++; if ({alu_a, alu_sci} !== {8'h03, 1'b0}) begin n_fail++; $display("FAIL shr_second_low: got %h %b want 03 0", alu_a, alu_sci); end
    @(negedge clk);
    n_cmp++; if ({rsp_data, rsp_co} !== {16'h8001, 1'b1}) begin n_fail++; $display("FAIL shr_result: got %h co %b want 8001 1", rsp_data, rsp_co); end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_xor;
    start_op(2'b11, 16'hF0F0, 16'hFFFF, 1'b1, 1'b0);
    n_cmp++; if ({alu_cmd, alu_a, alu_b, alu_sci} !== {4'b0101, 8'hF0, 8'hFF, 1'b0}) begin n_fail++; $display("FAIL xor_first_drive: got %b %h %h %b want 0101 f0 ff 0", alu_cmd, alu_a, alu_b, alu_sci); end
    @(negedge clk);
    n_cmp++; if (alu_sci !== 1'b0) begin n_fail++; $display("FAIL xor_second_sci: got %b want 0", alu_sci); end
    @(negedge clk);
    n_cmp++; if ({rsp_data, rsp_co} !== {16'h0F0F, 1'b0}) begin n_fail++; $display("FAIL xor_result: got %h co %b want 0f0f 0", rsp_data, rsp_co); end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    // req_valid stays high with different data throughout the in-flight op
    start_op(2'b00, 16'h0010, 16'h0020, 1'b0, 1'b1);
    req_a = 16'hAAAA; req_b = 16'h5555; req_op = 2'b00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({rsp_valid, req_ready, rsp_data, rsp_co} !== {2'b10, 16'h0030, 1'b0}) begin n_fail++; $display("FAIL bp_hold%0d: got v %b rdy %b %h co %b want 1 0 0030 0", i, rsp_valid, req_ready, rsp_data, rsp_co); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release: got %b%b want 10", req_ready, rsp_valid); end
    @(negedge clk);
    req_valid = 1'b0;
    // rsp_ready left high through FIRST/SECOND must not shortcut the op
    n_cmp++; if ({alu_a, alu_b} !== 16'hAA55) begin n_fail++; $display("FAIL b2b_first_drive: got %h %h want aa 55", alu_a, alu_b); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_data, rsp_co} !== {1'b1, 16'hFFFF, 1'b0}) begin n_fail++; $display("FAIL b2b_result: got v %b %h co %b want 1 ffff 0", rsp_valid, rsp_data, rsp_co); end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    start_op(2'b00, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({req_ready, rsp_valid, rsp_data, rsp_co, rsp_zero} !== {2'b10, 18'h0}) begin n_fail++; $display("FAIL midrst_outputs: got rdy %b v %b %h co %b z %b want 1 0 0000 0 0", req_ready, rsp_valid, rsp_data, rsp_co, rsp_zero); end
    n_cmp++; if (alu_cmd !== 4'b0011) begin n_fail++; $display("FAIL midrst_alu: got %b want 0011", alu_cmd); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(2'b00, 16'h1234, 16'h0001, 1'b0, 1'b0);
    n_cmp++; if ({alu_a, alu_b, alu_sci} !== {8'h34, 8'h01, 1'b0}) begin n_fail++; $display("FAIL postrst_first: got %h %h %b want 34 01 0", alu_a, alu_b, alu_sci); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_data, rsp_co} !== {1'b1, 16'h1235, 1'b0}) begin n_fail++; $display("FAIL postrst_result: got v %b %h co %b want 1 1235 0", rsp_valid, rsp_data, rsp_co); end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_add_carry;
    test_add_wrap;
    test_shl;
    test_shr;
    test_xor;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
